// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit stack CPU front end.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 18;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // instr keeps the decode stage's [0:17] ordering, bit 0 being the MSB
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [0:INSTR_W-1] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries with synchronous flush and occupancy count.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, the memory request FSM and jump redirects;
// buffered instructions come out of fetch_fifo.
module instr_fetch #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               i_clk,
    input  logic               i_rstN,
    output logic               o_imemReq,
    output logic [ADDR_W-1:0]  o_imemAddr,
    input  logic               i_imemAck,
    input  logic [0:INSTR_W-1] i_imemData,
    output logic [0:INSTR_W-1] o_instruction,
    output logic [ADDR_W-1:0]  o_instrPc,
    output logic               o_instrValid,
    input  logic               i_instrReady,
    input  logic               i_jTaken,
    input  logic [ADDR_W-1:0]  i_jTarget
);

    import cpu_pkg::fetch_state_t;
    import cpu_pkg::fetch_entry_t;
    import cpu_pkg::ENTRY_W;
    import cpu_pkg::IDLE;
    import cpu_pkg::REQ;
    import cpu_pkg::DRAIN;

    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam int                CNT_W1    = CNT_W + 1;
    localparam logic [CNT_W1-1:0] DEPTH_LIM = CNT_W1'(DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] target_d;

    logic              push;
    logic              pop;
    logic              flush;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W1-1:0] count_after;

    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] push_word;
    logic [ENTRY_W-1:0] head_word;

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = i_imemData;
    assign push_word        = push_entry;
    assign head_entry       = head_word;

    assign o_imemAddr    = fetch_pc_q;
    assign o_instrValid  = !empty;
    assign o_instruction = o_instrValid ? head_entry.instr : '0;
    assign o_instrPc     = o_instrValid ? head_entry.pc : '0;

    // A redirect flushes the queue and voids any pop in the same cycle.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        target_d    = target_q;
        o_imemReq   = 1'b0;
        push        = 1'b0;
        flush       = i_jTaken;
        pop         = o_instrValid && i_instrReady && !i_jTaken;
        count_after = '0;

        unique case (state_q)
            IDLE: begin
                if (i_jTaken) begin
                    fetch_pc_d = i_jTarget;
                    state_d    = REQ;
                end else if ({1'b0, count} < DEPTH_LIM) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                o_imemReq = 1'b1;
                if (i_jTaken) begin
                    if (i_imemAck) begin
                        fetch_pc_d = i_jTarget;
                        state_d    = REQ;
                    end else begin
                        target_d = i_jTarget;
                        state_d  = DRAIN;
                    end
                end else if (i_imemAck) begin
                    push        = 1'b1;
                    fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
                    count_after = {1'b0, count} + CNT_W1'(1) - CNT_W1'(pop);
                    state_d     = (count_after < DEPTH_LIM) ? REQ : IDLE;
                end
            end

            // The stale read keeps its address until acked; its data is dropped.
            DRAIN: begin
                o_imemReq = 1'b1;
                if (i_imemAck) begin
                    fetch_pc_d  = i_jTaken ? i_jTarget : target_q;
                    count_after = i_jTaken ? '0 : ({1'b0, count} - CNT_W1'(pop));
                    state_d     = (count_after < DEPTH_LIM) ? REQ : IDLE;
                end else if (i_jTaken) begin
                    target_d = i_jTarget;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rstN),
        .flush     (flush),
        .push      (push),
        .push_entry(push_word),
        .pop       (pop),
        .head      (head_word),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against an address-queue reference model.
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [0:17] imem_data = '0;
    logic [0:17] instruction;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        j_taken = 1'b0;
    logic [15:0] j_target = '0;

    int checks = 0;
    int errors = 0;

    // reference model: addresses of words sitting in the prefetch queue
    logic [15:0] q[$];
    logic [15:0] popped[$];
    logic        stale;
    logic        prev_pending;
    logic [15:0] prev_addr;
    logic [15:0] next_fetch;
    logic        new_req;
    logic        last_ack;
    logic        last_valid;
    logic        mem_busy;
    int          mem_wait;
    int          lat_mode;
    int          ack_count;
    int          pop_total;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W  (16),
        .INSTR_W (18),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .i_clk        (clk),
        .i_rstN       (rst_n),
        .o_imemReq    (imem_req),
        .o_imemAddr   (imem_addr),
        .i_imemAck    (imem_ack),
        .i_imemData   (imem_data),
        .o_instruction(instruction),
        .o_instrPc    (instr_pc),
        .o_instrValid (instr_valid),
        .i_instrReady (instr_ready),
        .i_jTaken     (j_taken),
        .i_jTarget    (j_target)
    );

    function automatic logic [17:0] memf(input logic [15:0] a);
        return {2'b10, a ^ 16'hA5A1};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        popped.delete();
        stale        = 1'b0;
        prev_pending = 1'b0;
        prev_addr    = RESET_PC;
        next_fetch   = RESET_PC;
        mem_busy     = 1'b0;
        mem_wait     = 0;
        ack_count    = 0;
    endtask

    // One clock cycle: memory response, model step, edge, then output checks.
    task automatic tick();
        logic ack_now;
        logic jump;
        logic pop;
        ack_now = 1'b0;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (mem_wait == 0) begin
                ack_now  = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        imem_ack  = ack_now;
        imem_data = ack_now ? memf(imem_addr) : 18'($urandom);

        jump       = j_taken;
        pop        = instr_valid && instr_ready && !jump;
        last_ack   = ack_now;
        last_valid = instr_valid;
        if (ack_now) ack_count++;
        if (pop) begin
            popped.push_back(instr_pc);
            pop_total++;
        end
        if (jump) begin
            q.delete();
            stale      = imem_req && !ack_now;
            next_fetch = j_target;
        end else begin
            if (pop) void'(q.pop_front());
            if (ack_now) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    q.push_back(imem_addr);
                    next_fetch = imem_addr + 16'd1;
                end
            end
        end
        prev_pending = imem_req && !ack_now;
        prev_addr    = imem_addr;

        @(posedge clk);
        #1;

        new_req = 1'b0;
        if (prev_pending) begin
            check_eq("req_held", 32'(imem_req), 32'd1);
            check_eq("addr_held", 32'(imem_addr), 32'(prev_addr));
        end else if (imem_req) begin
            new_req = 1'b1;
            check_eq("req_addr", 32'(imem_addr), 32'(next_fetch));
            check_eq("req_space", 32'(q.size() < DEPTH), 32'd1);
        end
        check_eq("valid", 32'(instr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("head_pc", 32'(instr_pc), 32'(q[0]));
            check_eq("head_instr", 32'(instruction), 32'(memf(q[0])));
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        j_taken  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'(RESET_PC));
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", 32'(instruction), 32'd0);
        check_eq("rst_pc", 32'(instr_pc), 32'd0);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!instr_valid && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_new_req(input string tag, input int limit);
        int n;
        n = 0;
        new_req = 1'b0;
        while (!new_req && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(new_req), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        pop_total = 0;
        model_reset();

        // zero-wait memory, decode always ready
        lat_mode    = 0;
        instr_ready = 1'b1;
        do_reset();
        tick();
        check_eq("t1_req", 32'(imem_req), 32'd1);
        tick();
        check_eq("t1_instr", 32'(instruction), 32'h2A5A1);
        check_eq("t1_pc", 32'(instr_pc), 32'd0);
        check_eq("t1_valid", 32'(instr_valid), 32'd1);

        // decode stalled: queue fills after two acks, then drains in order
        instr_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        check_eq("t2_acks", 32'(ack_count), 32'd2);
        check_eq("t2_req_idle", 32'(imem_req), 32'd0);
        check_eq("t2_full_valid", 32'(instr_valid), 32'd1);
        popped.delete();
        instr_ready = 1'b1;
        repeat (6) tick();
        check_eq("t2_pops", 32'(popped.size() >= 3), 32'd1);
        if (popped.size() >= 3) begin
            check_eq("t2_pop0", 32'(popped[0]), 32'd0);
            check_eq("t2_pop1", 32'(popped[1]), 32'd1);
            check_eq("t2_pop2", 32'(popped[2]), 32'd2);
        end

        // jump during a 3-cycle memory wait
        lat_mode = 3;
        do_reset();
        tick();
        j_taken  = 1'b1;
        j_target = 16'h0100;
        tick();
        j_taken = 1'b0;
        wait_new_req("t3_req_seen", 20);
        check_eq("t3_req_addr", 32'(imem_addr), 32'h0100);
        wait_valid("t3_valid", 20);
        check_eq("t3_pc", 32'(instr_pc), 32'h0100);

        // jump coinciding with an ack and a pop
        lat_mode = 0;
        do_reset();
        tick();
        tick();
        j_taken  = 1'b1;
        j_target = 16'h0040;
        tick();
        j_taken = 1'b0;
        check_eq("t4_cond", 32'({last_ack, last_valid}), 32'd3);
        check_eq("t4_flush", 32'(instr_valid), 32'd0);
        wait_valid("t4_valid", 10);
        check_eq("t4_pc", 32'(instr_pc), 32'h0040);

        // address wrap and full throughput from zero-wait memory
        j_taken  = 1'b1;
        j_target = 16'hFFFE;
        tick();
        j_taken = 1'b0;
        popped.delete();
        repeat (8) tick();
        check_eq("t5_rate", 32'(popped.size()), 32'd7);
        if (popped.size() >= 3) begin
            check_eq("t5_pc0", 32'(popped[0]), 32'hFFFE);
            check_eq("t5_pc1", 32'(popped[1]), 32'hFFFF);
            check_eq("t5_pc2", 32'(popped[2]), 32'h0000);
        end

        // half-cycle reset pulse with a read outstanding and the queue occupied
        lat_mode    = 3;
        instr_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        check_eq("t6_pre", 32'({imem_req, instr_valid}), 32'd3);
        imem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_req_async", 32'(imem_req), 32'd0);
        check_eq("t6_valid_async", 32'(instr_valid), 32'd0);
        #3 rst_n = 1'b1;
        model_reset();
        tick();
        check_eq("t6_restart_req", 32'(imem_req), 32'd1);
        check_eq("t6_restart_addr", 32'(imem_addr), 32'(RESET_PC));

        // randomized latency, back-pressure and redirects
        lat_mode = -1;
        do_reset();
        pop_total = 0;
        for (int i = 0; i < 2000; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            j_taken     = ($urandom_range(0, 29) == 0);
            j_target    = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                       : 16'($urandom);
            tick();
        end
        j_taken = 1'b0;
        check_eq("progress", 32'(pop_total >= 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
